// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared constants and helpers for the round-robin stream multiplexer.
//   NUM_IN_DEF / WIDTH_DEF : default channel count and payload width
//   lock_state_e           : grant-lock state used when STREAM_MUX_LAST_EN is set
//   rr_next()              : round-robin successor of a channel index
//   rr_wrap()              : (base + off) mod num for base, off < num
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam int NUM_IN_DEF = 32'sd4;
    localparam int WIDTH_DEF  = 32'sd8;

    // Grant lock: FREE re-arbitrates every beat, HELD pins the grant to one
    // channel until that channel transfers a beat marked last.
    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Channel that follows idx in round-robin order, wrapping at num.
    function automatic int rr_next(input int idx, input int num);
        int nxt;
        if (idx >= num - 32'sd1) begin
            nxt = 32'sd0;
        end else begin
            nxt = idx + 32'sd1;
        end
        return nxt;
    endfunction

    // Modular add without a divider; both operands are already below num.
    function automatic int rr_wrap(input int base, input int off, input int num);
        int sum;
        sum = base + off;
        if (sum >= num) begin
            sum = sum - num;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin channel arbiter for stream_mux_rr. Holds the search pointer and,
// when STREAM_MUX_LAST_EN is defined, the packet lock.
//
// Ports
//   clk_i        : clock, state updates on the rising edge
//   rst_ni       : asynchronous active-low reset (ptr = 0, lock cleared)
//   valid_i      : per-channel request
//   last_i       : per-channel end-of-packet flag (STREAM_MUX_LAST_EN only)
//   advance_i    : the current grant is consumed at the coming edge when the
//                  grant is valid (the output register is loading)
//   gnt_idx_o    : granted channel index (combinational)
//   gnt_valid_o  : a channel is granted this cycle (combinational)
//
// Configuration macro: STREAM_MUX_LAST_EN
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_IN-1:0] valid_i,
`ifdef STREAM_MUX_LAST_EN
    input  logic [NUM_IN-1:0] last_i,
`endif
    input  logic              advance_i,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              gnt_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] search_idx_s;
    logic             search_hit_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             gnt_valid_s;
    logic             xfer_s;

`ifdef STREAM_MUX_LAST_EN
    lock_state_e      lock_q;
    lock_state_e      lock_d;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] lock_idx_d;
`endif

    // Priority search: first requesting channel starting at ptr, wrapping.
    always_comb begin
        int cand;
        cand         = 32'sd0;
        search_hit_s = 1'b0;
        search_idx_s = {IDX_W{1'b0}};
        for (int off = 0; off < NUM_IN; off++) begin
            cand = rr_wrap(int'(ptr_q), off, NUM_IN);
            if (!search_hit_s && valid_i[cand[IDX_W-1:0]]) begin
                search_hit_s = 1'b1;
                search_idx_s = cand[IDX_W-1:0];
            end else begin
                search_hit_s = search_hit_s;
            end
        end
    end

    // Grant selection: a held lock overrides the search, even if the locked
    // channel is momentarily idle (then nothing is granted).
    always_comb begin
        gnt_idx_s   = search_idx_s;
        gnt_valid_s = search_hit_s;
`ifdef STREAM_MUX_LAST_EN
        case (lock_q)
            LOCK_HELD: begin
                gnt_idx_s   = lock_idx_q;
                gnt_valid_s = valid_i[lock_idx_q];
            end
            LOCK_FREE: begin
                gnt_idx_s   = search_idx_s;
                gnt_valid_s = search_hit_s;
            end
            default: begin
                gnt_idx_s   = search_idx_s;
                gnt_valid_s = search_hit_s;
            end
        endcase
`endif
    end

    assign xfer_s = advance_i && gnt_valid_s;

    // Pointer moves past the winner on every accepted beat, otherwise holds.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
            ptr_d = IDX_W'(rr_next(int'(gnt_idx_s), NUM_IN));
        end else begin
            ptr_d = ptr_q;
        end
    end

`ifdef STREAM_MUX_LAST_EN
    // Lock next state: a non-last beat pins the grant, a last beat frees it.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (xfer_s) begin
            if (last_i[gnt_idx_s]) begin
                lock_d     = LOCK_FREE;
                lock_idx_d = lock_idx_q;
            end else begin
                lock_d     = LOCK_HELD;
                lock_idx_d = gnt_idx_s;
            end
        end else begin
            lock_d     = lock_q;
            lock_idx_d = lock_idx_q;
        end
    end
`endif

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= {IDX_W{1'b0}};
`ifdef STREAM_MUX_LAST_EN
            lock_q     <= LOCK_FREE;
            lock_idx_q <= {IDX_W{1'b0}};
`endif
        end else begin
            ptr_q      <= ptr_d;
`ifdef STREAM_MUX_LAST_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign gnt_idx_o   = gnt_idx_s;
    assign gnt_valid_o = gnt_valid_s;

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// NUM_IN-to-1 valid/ready stream multiplexer with round-robin arbitration and
// a single registered output stage (1-cycle latency, 1 beat/cycle).
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset; clears output register and ptr
//   valid_i  : [NUM_IN] per-channel data present
//   data_i   : [NUM_IN][WIDTH] per-channel payload
//   last_i   : [NUM_IN] end-of-packet flag (STREAM_MUX_LAST_EN only)
//   ready_o  : [NUM_IN] one-hot (or zero) accept strobe, combinational
//   valid_o  : output beat present (registered)
//   data_o   : output payload (registered)
//   sel_o    : source channel of data_o (registered)
//   last_o   : end-of-packet of data_o (registered, STREAM_MUX_LAST_EN only)
//   ready_i  : downstream accept
//
// Configuration macro: STREAM_MUX_LAST_EN adds last_i/last_o and packet lock.
// -----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_IN-1:0]            valid_i,
    input  logic [NUM_IN-1:0][WIDTH-1:0] data_i,
`ifdef STREAM_MUX_LAST_EN
    input  logic [NUM_IN-1:0]            last_i,
    output logic                         last_o,
`endif
    output logic [NUM_IN-1:0]            ready_o,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(NUM_IN)-1:0]    sel_o,
    input  logic                         ready_i
);

    localparam int IDX_W = $clog2(NUM_IN);

    logic             load_en_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             gnt_valid_s;

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] sel_d;
`ifdef STREAM_MUX_LAST_EN
    logic             last_q;
    logic             last_d;
`endif

    // The output stage can take a new beat when empty or being drained now.
    assign load_en_s = !valid_q || ready_i;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
`ifdef STREAM_MUX_LAST_EN
        .last_i      (last_i),
`endif
        .advance_i   (load_en_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Only the granted channel sees the accept strobe, and only if we can load.
    always_comb begin
        ready_o = {NUM_IN{1'b0}};
        if (load_en_s && gnt_valid_s) begin
            ready_o[gnt_idx_s] = 1'b1;
        end else begin
            ready_o = {NUM_IN{1'b0}};
        end
    end

    // Output register next state: load the winner, go empty when nothing is
    // granted (payload and sel keep their last values), or hold on stall.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifdef STREAM_MUX_LAST_EN
        last_d  = last_q;
`endif
        if (load_en_s) begin
            if (gnt_valid_s) begin
                valid_d = 1'b1;
                data_d  = data_i[gnt_idx_s];
                sel_d   = gnt_idx_s;
`ifdef STREAM_MUX_LAST_EN
                last_d  = last_i[gnt_idx_s];
`endif
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register; reset discards any held beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            sel_q   <= {IDX_W{1'b0}};
`ifdef STREAM_MUX_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef STREAM_MUX_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sel_o   = sel_q;
`ifdef STREAM_MUX_LAST_EN
    assign last_o  = last_q;
`endif

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Scoreboard bench for stream_mux_rr (NUM_IN = 4, WIDTH = 8). A reference
// model predicts each accepted beat and pushes it into a queue; a monitor pops
// and compares whenever the DUT drains a beat. Directed phases cover reset,
// the all-valid rotation, backpressure, wrap/skip, drain+load and (with
// STREAM_MUX_LAST_EN) the packet lock, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] sel;
        logic          last;
    } beat_t;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [N-1:0]        valid_i;
    logic [N-1:0][W-1:0] data_i;
    logic [N-1:0]        ready_o;
    logic                valid_o;
    logic [W-1:0]        data_o;
    logic [IW-1:0]       sel_o;
    logic                ready_i;
`ifdef STREAM_MUX_LAST_EN
    logic [N-1:0]        last_i;
    logic                last_o;
`endif

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t m_hold = '0;
    int    m_ptr = 0;
    bit    m_lock = 1'b0;
    int    m_lock_ch = 0;

    always #10 clk_i = ~clk_i;

    stream_mux_rr #(
        .NUM_IN (N),
        .WIDTH  (W)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .data_i  (data_i),
`ifdef STREAM_MUX_LAST_EN
        .last_i  (last_i),
        .last_o  (last_o),
`endif
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .ready_i (ready_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Round-robin rule: first requesting channel from ptr upward mod N,
    // unless a packet lock pins the grant.
    function automatic int model_grant(input logic [N-1:0] v);
        int c;
        if (m_lock) begin
            return v[m_lock_ch] ? m_lock_ch : -1;
        end
        for (int off = 0; off < N; off++) begin
            c = (m_ptr + off) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: decides at negedge+3 what the coming edge will accept.
    initial begin : model
        int           g;
        logic [N-1:0] er;
        beat_t        b;
        forever begin
            @(negedge clk_i);
            #3;
            if (!rst_ni) begin
                exp_q.delete();
                m_ptr     = 0;
                m_lock    = 1'b0;
                m_lock_ch = 0;
            end else begin
                g = -1;
                if (exp_q.size() == 0) g = model_grant(valid_i);
                er = '0;
                if (g >= 0) er[g] = 1'b1;
                check("ready_o", 32'(ready_o), 32'(er));
                if (g >= 0) begin
                    b.data = data_i[g];
                    b.sel  = g[IW-1:0];
                    b.last = 1'b0;
`ifdef STREAM_MUX_LAST_EN
                    b.last = last_i[g];
                    if (last_i[g]) begin
                        m_lock = 1'b0;
                    end else begin
                        m_lock    = 1'b1;
                        m_lock_ch = g;
                    end
`endif
                    exp_q.push_back(b);
                    m_ptr = (g + 1) % N;
                end
            end
        end
    end

    // Monitor: compares the presented beat and pops it when drained.
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_ni) begin
                m_hold = '0;
            end else begin
                check("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("data_o", 32'(data_o), 32'(exp_q[0].data));
                    check("sel_o", 32'(sel_o), 32'(exp_q[0].sel));
`ifdef STREAM_MUX_LAST_EN
                    check("last_o", 32'(last_o), 32'(exp_q[0].last));
`endif
                    if (ready_i) m_hold = exp_q.pop_front();
                end else begin
                    check("idle data_o hold", 32'(data_o), 32'(m_hold.data));
                    check("idle sel_o hold", 32'(sel_o), 32'(m_hold.sel));
                end
            end
        end
    end

    // Stimulus and directed checks.
    initial begin : driver
        rst_ni  = 1'b0;
        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b0;
`ifdef STREAM_MUX_LAST_EN
        last_i  = '1;
`endif
        repeat (2) @(negedge clk_i);
        #1;
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset data_o", 32'(data_o), 32'd0);
        check("reset sel_o", 32'(sel_o), 32'd0);
        check("reset ready_o", 32'(ready_o), 32'd0);
        rst_ni = 1'b1;

        // All channels valid: rotation 0,1,2,3,0.
        @(negedge clk_i);
        valid_i = 4'b1111;
        data_i  = {8'h44, 8'h33, 8'h22, 8'h11};
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            #1;
            check("rr sel_o", 32'(sel_o), 32'(k % 4));
            check("rr data_o", 32'(data_o), 32'(8'h11 * (k % 4 + 1)));
        end

        // Backpressure on the 8'h22 beat for three cycles.
        @(negedge clk_i);
        ready_i = 1'b0;
        repeat (3) begin
            #1;
            check("stall data_o", 32'(data_o), 32'h22);
            check("stall valid_o", 32'(valid_o), 32'd1);
            check("stall ready_o", 32'(ready_o), 32'd0);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("after stall data_o", 32'(data_o), 32'h33);
        check("after stall sel_o", 32'(sel_o), 32'd2);

        // Wrap and skip: ptr = 3, only channel 1 requests.
        valid_i = 4'b0010;
        @(negedge clk_i);
        #1;
        check("wrap sel_o", 32'(sel_o), 32'd1);
        check("wrap data_o", 32'(data_o), 32'h22);
        valid_i = 4'b0000;
        @(negedge clk_i);
        #1;
        check("drain valid_o", 32'(valid_o), 32'd0);
        check("drain data hold", 32'(data_o), 32'h22);
        valid_i = 4'b1111;
        @(negedge clk_i);
        #1;
        check("ptr after wrap", 32'(sel_o), 32'd2);

        // Drain and load in the same cycle, channel 2 only.
        valid_i = 4'b0100;
        @(negedge clk_i);
        #1;
        check("no bubble valid_o", 32'(valid_o), 32'd1);
        check("no bubble sel_o", 32'(sel_o), 32'd2);
        ready_i = 1'b0;

        // Reset mid-stream while a beat is held.
        #3;
        rst_ni = 1'b0;
        #2;
        check("async rst valid_o", 32'(valid_o), 32'd0);
        check("async rst data_o", 32'(data_o), 32'd0);
        check("async rst sel_o", 32'(sel_o), 32'd0);
        @(negedge clk_i);
        valid_i = 4'b1111;
        ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("first grant after reset", 32'(sel_o), 32'd0);

`ifdef STREAM_MUX_LAST_EN
        // Channel 1 packet of three beats while channel 0 keeps requesting.
        valid_i = 4'b0011;
        last_i  = 4'b1101;
        @(negedge clk_i);
        #1;
        check("lock beat1 sel_o", 32'(sel_o), 32'd1);
        @(negedge clk_i);
        #1;
        check("lock beat2 sel_o", 32'(sel_o), 32'd1);
        check("lock beat2 last_o", 32'(last_o), 32'd0);
        last_i = 4'b1111;
        @(negedge clk_i);
        #1;
        check("lock beat3 sel_o", 32'(sel_o), 32'd1);
        check("lock beat3 last_o", 32'(last_o), 32'd1);
        @(negedge clk_i);
        #1;
        check("after release sel_o", 32'(sel_o), 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            valid_i = 4'($urandom_range(0, 15));
            data_i  = 32'($urandom());
            ready_i = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LAST_EN
            last_i  = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
`endif
        end

        @(negedge clk_i);
        valid_i = '0;
        ready_i = 1'b1;
`ifdef STREAM_MUX_LAST_EN
        last_i  = '1;
`endif
        repeat (4) @(negedge clk_i);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stream_mux_rr

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
- REQ-001: Parameter NUM_IN, default 4, number of input channels (2..16).
- REQ-002: Parameter WIDTH, default 8, data width per channel in bits.
- REQ-003: Port clk_i, input, 1 bit; single clock, all state updates on its rising edge.
- REQ-004: Port rst_ni, input, 1 bit; reset is asynchronous and active-low.
- REQ-005: Port valid_i, input, [NUM_IN-1:0]; per-channel "data present" flag.
- REQ-006: Port data_i, input, [NUM_IN-1:0][WIDTH-1:0]; per-channel payload.
- REQ-007: Port ready_o, output, [NUM_IN-1:0]; per-channel accept strobe.
- REQ-008: Port valid_o, output, 1 bit; registered output holds a beat.
- REQ-009: Port data_o, output, [WIDTH-1:0]; registered payload.
- REQ-010: Port sel_o, output, [$clog2(NUM_IN)-1:0]; source channel index of the beat in data_o.
- REQ-011: Port ready_i, input, 1 bit; downstream accept.

Function
- REQ-012: Input transfer on channel k SHALL occur when valid_i[k] and ready_o[k] are both 1 at a clock edge; output transfer when valid_o and ready_i are both 1.
- REQ-013: Internal load_en = !valid_o || ready_i; the output register SHALL load only when load_en is 1.
- REQ-014: Arbitration SHALL be round-robin: the grant goes to the first channel with valid_i set, searching from pointer ptr upward modulo NUM_IN.
- REQ-015: ready_o SHALL be one-hot or zero: only the granted channel sees ready_o = load_en; all others 0.
- REQ-016: ready_o SHALL depend combinationally on valid_i, ptr and ready_i; valid_o and data_o SHALL NOT depend combinationally on any input.
- REQ-017: On an input transfer from channel g, data_o <= data_i[g], sel_o <= g, valid_o <= 1, ptr <= (g+1) mod NUM_IN, at the same edge.
- REQ-018: Latency from input transfer to valid_o is exactly 1 cycle. Sustained throughput is 1 beat/cycle when ready_i is held 1.
- REQ-019: If load_en = 1 and no valid_i bit is set, valid_o <= 0. data_o and sel_o SHALL hold their last values and ptr is unchanged.
- REQ-020: While valid_o = 1 and ready_i = 0, data_o, sel_o, valid_o and ptr SHALL hold, and all ready_o SHALL be 0.
- REQ-021: Simultaneous output drain and input accept in one cycle SHALL replace the beat with no bubble.
- REQ-022: Pointer wrap: from ptr = NUM_IN-1, the search order is NUM_IN-1, 0, 1, ...
- REQ-023: Any channel whose valid_i is held 1 SHALL be granted within NUM_IN input transfers (no starvation).

Reset
- REQ-024: Asserting rst_ni low SHALL immediately force valid_o = 0, data_o = 0, sel_o = 0, ptr = 0 and lock state cleared, independent of clk_i.
- REQ-025: A beat held in the output register when reset asserts SHALL be discarded. The first grant after release SHALL search from channel 0.

Configuration
- REQ-026: Macro STREAM_MUX_LAST_EN. When defined, the block SHALL add ports last_i [NUM_IN-1:0] (input) and last_o (output, registered alongside data_o, reset 0).
- REQ-027: With STREAM_MUX_LAST_EN defined, a transfer with last_i[g] = 0 SHALL lock the grant to g. The lock persists, including while valid_i[g] = 0, until a transfer from g with last_i[g] = 1. That transfer releases the lock and sets ptr <= g+1.
- REQ-028: Without STREAM_MUX_LAST_EN defined, the block has no last ports and re-arbitrates on every beat.

Structure
- REQ-029: Package stream_mux_pkg SHALL hold default constants NUM_IN_DEF = 4 and WIDTH_DEF = 8, plus the helper function for the round-robin next index.
- REQ-030: Sub-module rr_arbiter SHALL contain ptr, the priority search and the lock logic. It outputs the grant index and a grant-valid flag. The top level holds the output register.

Verification
- REQ-031: Reset: rst_ni = 0 mid-stream with valid_o = 1 -> valid_o, data_o and sel_o read 0 before the next edge. After release, the first grant goes to channel 0.
- REQ-032: Round-robin with all valid: NUM_IN = 4, valid_i = 4'b1111, data_i = {8'h44, 8'h33, 8'h22, 8'h11}, ready_i = 1 -> sel_o sequence 0,1,2,3,0 on consecutive cycles, data_o 11,22,33,44,11.
- REQ-033: Backpressure: ready_i = 0 for 3 cycles with valid_o = 1, data_o = 8'h22 -> data_o stays 8'h22, ready_o = 0, ptr unchanged. The next beat follows 1 cycle after ready_i returns to 1.
- REQ-034: Wrap and skip: ptr = 3, valid_i = 4'b0010 -> grant to channel 1, ptr becomes 2. Then valid_i = 0 -> valid_o drops to 0 after one drain.
- REQ-035: Simultaneous drain and load: valid_o = 1, ready_i = 1, valid_i[2] = 1 -> new beat from channel 2 in the next cycle, no idle cycle.
- REQ-036: STREAM_MUX_LAST_EN: channel 1 sends 3 beats with last on the third, while channel 0 is valid throughout -> sel_o reads 1,1,1 before channel 0 is granted.
